// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access encoding, SE error types and the SE sequencer state enum.
package rv_iopmp_pkg;

    typedef enum logic [2:0] {
        ACCESS_NONE      = 3'd0,
        ACCESS_READ      = 3'd1,
        ACCESS_WRITE     = 3'd2,
        ACCESS_EXECUTION = 3'd4
    } access_t;

    localparam logic [2:0] ERR_EXEC    = 3'd3;
    localparam logic [2:0] ERR_NO_HIT  = 3'd5;
    localparam logic [2:0] ERR_UNKNOWN = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } se_seq_state_t;

endpackage

// File: rtl/rv_iopmp_dl_se_win.sv
// Combinational evaluator for one match window: the lowest matching slot decides the verdict.
module rv_iopmp_dl_se_win
    import rv_iopmp_pkg::*;
#(
    parameter int NUMBER_INSTANCES = 8
) (
    input  logic [NUMBER_INSTANCES-1:0] match,
    input  logic [NUMBER_INSTANCES-1:0] allow,
    input  logic [8:0]                  offset,
    input  access_t                     access,
    output logic                        hit,
    output logic                        hit_allow,
    output logic                        err,
    output logic [2:0]                  err_type,
    output logic [15:0]                 err_index
);

    logic [8:0] slot;
    logic       sel_allow;

    always_comb begin
        hit       = 1'b0;
        slot      = '0;
        sel_allow = 1'b0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = NUMBER_INSTANCES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                slot      = 9'(i);
                sel_allow = allow[i];
            end
        end
        hit_allow = hit & sel_allow;
        err       = hit & ~sel_allow;
        err_type  = 3'd0;
        err_index = 16'd0;
        if (err) begin
            case (access)
                ACCESS_READ:      err_type = 3'd1;
                ACCESS_WRITE:     err_type = 3'd2;
                ACCESS_EXECUTION: err_type = ERR_EXEC;
                default:          err_type = ERR_UNKNOWN;
            endcase
            err_index = {7'd0, offset} + {7'd0, slot};
        end
    end

endmodule

// File: rtl/rv_iopmp_dl_se_seq.sv
// SE sequencer: steps a narrow match window across the entry table and returns a
// registered allow/error verdict on a valid/ready channel.
module rv_iopmp_dl_se_seq
    import rv_iopmp_pkg::*;
#(
    parameter int NUMBER_ENTRIES   = 8,
    parameter int NUMBER_INSTANCES = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  access_t                     req_access_i,
    output logic [8:0]                  win_offset_o,
    input  logic [NUMBER_INSTANCES-1:0] win_match_i,
    input  logic [NUMBER_INSTANCES-1:0] win_allow_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic                        rsp_allow_o,
    output logic                        rsp_err_o,
    output logic [2:0]                  rsp_err_type_o,
    output logic [15:0]                 rsp_err_index_o
);

    localparam logic [8:0] LAST_OFFSET = 9'(NUMBER_ENTRIES - NUMBER_INSTANCES);
    localparam logic [8:0] STEP        = 9'(NUMBER_INSTANCES);

    se_seq_state_t state_q, state_d;
    logic [8:0]    offset_q, offset_d;
    access_t       access_q, access_d;
    logic          allow_q, allow_d;
    logic          err_q, err_d;
    logic [2:0]    type_q, type_d;
    logic [15:0]   index_q, index_d;

    logic          win_hit, win_allow, win_err;
    logic [2:0]    win_type;
    logic [15:0]   win_index;
    logic          accept;

    rv_iopmp_dl_se_win #(
        .NUMBER_INSTANCES(NUMBER_INSTANCES)
    ) u_win (
        .match     (win_match_i),
        .allow     (win_allow_i),
        .offset    (offset_q),
        .access    (access_q),
        .hit       (win_hit),
        .hit_allow (win_allow),
        .err       (win_err),
        .err_type  (win_type),
        .err_index (win_index)
    );

    // Accepting in RESP alongside the verdict handshake removes the bubble between requests.
    assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        access_d = access_q;
        allow_d  = allow_q;
        err_d    = err_q;
        type_d   = type_q;
        index_d  = index_q;
        case (state_q)
            SCAN: begin
                if (win_hit) begin
                    state_d = RESP;
                    allow_d = win_allow;
                    err_d   = win_err;
                    type_d  = win_type;
                    index_d = win_index;
                end else if (offset_q == LAST_OFFSET) begin
                    state_d = RESP;
                    allow_d = 1'b0;
                    err_d   = 1'b1;
                    type_d  = ERR_NO_HIT;
                    index_d = 16'd0;
                end else begin
                    offset_d = offset_q + STEP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            offset_d = 9'd0;
            access_d = req_access_i;
            if (enable_i) begin
                state_d = SCAN;
            end else begin
                state_d = RESP;
                allow_d = 1'b0;
                err_d   = 1'b0;
                type_d  = 3'd0;
                index_d = 16'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            offset_q <= 9'd0;
            access_q <= ACCESS_NONE;
            allow_q  <= 1'b0;
            err_q    <= 1'b0;
            type_q   <= 3'd0;
            index_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            access_q <= access_d;
            allow_q  <= allow_d;
            err_q    <= err_d;
            type_q   <= type_d;
            index_q  <= index_d;
        end
    end

    assign win_offset_o    = offset_q;
    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_allow_o     = allow_q;
    assign rsp_err_o       = err_q;
    assign rsp_err_type_o  = type_q;
    assign rsp_err_index_o = index_q;

endmodule

// File: tb/tb_rv_iopmp_dl_se_seq.sv
// Directed bench for rv_iopmp_dl_se_seq with a 16-entry table and a 4-wide window.
module tb_rv_iopmp_dl_se_seq;
    import rv_iopmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    access_t     req_access = ACCESS_READ;
    logic [8:0]  win_offset;
    logic [3:0]  win_match;
    logic [3:0]  win_allow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_allow;
    logic        rsp_err;
    logic [2:0]  rsp_err_type;
    logic [15:0] rsp_err_index;

    logic [3:0]  tm [4];
    logic [3:0]  ta [4];
    logic [8:0]  offs [$];
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        win_match = tm[win_offset[3:2]];
        win_allow = ta[win_offset[3:2]];
    end

    rv_iopmp_dl_se_seq #(
        .NUMBER_ENTRIES(16),
        .NUMBER_INSTANCES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_access_i(req_access),
        .win_offset_o(win_offset), .win_match_i(win_match), .win_allow_i(win_allow),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
        .rsp_err_o(rsp_err), .rsp_err_type_o(rsp_err_type), .rsp_err_index_o(rsp_err_index)
    );

    task automatic set_tables(input logic [15:0] m, input logic [15:0] a);
        for (int w = 0; w < 4; w++) begin
            tm[w] = m[w*4 +: 4];
            ta[w] = a[w*4 +: 4];
        end
    endtask

    // Accept one request (cycle 0), flip enable afterwards, then wait for the verdict.
    task automatic issue(input access_t acc, input logic en);
        req_access = acc;
        enable     = en;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        enable    = ~en;
        cyc       = 1;
        offs.delete();
        while (!rsp_valid && cyc < 40) begin
            offs.push_back(win_offset);
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, win_offset, rsp_valid, rsp_allow, rsp_err, rsp_err_type, rsp_err_index} !== {1'b1, 9'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset: ready=%0b off=%0d vld=%0b allow=%0b err=%0b type=%0d idx=%0d, want 1 0 0 0 0 0 0",
                     req_ready, win_offset, rsp_valid, rsp_allow, rsp_err, rsp_err_type, rsp_err_index);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hit_win2();
        set_tables(16'h0200, 16'h0000);
        issue(ACCESS_READ, 1'b1);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL hit_win2 latency: got %0d want 4", cyc); end
        checks++;
        if (offs.size() != 3 || offs[0] !== 9'd0 || offs[1] !== 9'd4 || offs[2] !== 9'd8) begin
            errors++; $display("FAIL hit_win2 offsets: got %p want 0 4 8", offs);
        end
        checks++;
        if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_index} !== {1'b0, 1'b1, 3'd1, 16'd9}) begin
            errors++;
            $display("FAIL hit_win2 verdict: allow=%0b err=%0b type=%0d idx=%0d want 0 1 1 9", rsp_allow, rsp_err, rsp_err_type, rsp_err_index);
        end
        release_rsp();
    endtask

    task automatic test_priority();
        set_tables(16'h0006, 16'h0004);
        issue(ACCESS_EXECUTION, 1'b1);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL priority latency: got %0d want 2", cyc); end
        checks++;
        if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_index} !== {1'b0, 1'b1, 3'd3, 16'd1}) begin
            errors++;
            $display("FAIL priority verdict: allow=%0b err=%0b type=%0d idx=%0d want 0 1 3 1", rsp_allow, rsp_err, rsp_err_type, rsp_err_index);
        end
        release_rsp();
    endtask

    task automatic test_allow_and_unknown();
        set_tables(16'h0080, 16'h0080);
        issue(ACCESS_WRITE, 1'b1);
        checks++;
        if (cyc !== 3 || rsp_allow !== 1'b1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL allow_hit: cyc=%0d allow=%0b err=%0b want 3 1 0", cyc, rsp_allow, rsp_err);
        end
        release_rsp();
        set_tables(16'h8000, 16'h0000);
        issue(ACCESS_NONE, 1'b1);
        checks++;
        if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_index} !== {1'b0, 1'b1, 3'd7, 16'd15}) begin
            errors++;
            $display("FAIL unknown_access: allow=%0b err=%0b type=%0d idx=%0d want 0 1 7 15", rsp_allow, rsp_err, rsp_err_type, rsp_err_index);
        end
        release_rsp();
    endtask

    task automatic test_no_hit();
        set_tables(16'h0000, 16'hFFFF);
        issue(ACCESS_WRITE, 1'b1);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL no_hit latency: got %0d want 5", cyc); end
        checks++;
        if (offs.size() != 4 || offs[0] !== 9'd0 || offs[1] !== 9'd4 || offs[2] !== 9'd8 || offs[3] !== 9'd12) begin
            errors++; $display("FAIL no_hit offsets: got %p want 0 4 8 12", offs);
        end
        checks++;
        if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_index} !== {1'b0, 1'b1, 3'd5, 16'd0}) begin
            errors++;
            $display("FAIL no_hit verdict: allow=%0b err=%0b type=%0d idx=%0d want 0 1 5 0", rsp_allow, rsp_err, rsp_err_type, rsp_err_index);
        end
        release_rsp();
    endtask

    task automatic test_disabled();
        set_tables(16'h1111, 16'h0000);
        issue(ACCESS_READ, 1'b0);
        checks++;
        if (cyc !== 1 || win_offset !== 9'd0) begin
            errors++; $display("FAIL disabled latency: cyc=%0d off=%0d want 1 0", cyc, win_offset);
        end
        checks++;
        if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_index} !== 21'd0) begin
            errors++;
            $display("FAIL disabled verdict: allow=%0b err=%0b type=%0d idx=%0d want all 0", rsp_allow, rsp_err, rsp_err_type, rsp_err_index);
        end
        release_rsp();
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        set_tables(16'h0080, 16'h0000);
        issue(ACCESS_READ, 1'b1);
        checks++;
        if (cyc !== 3 || rsp_err_index !== 16'd7) begin
            errors++; $display("FAIL b2b first: cyc=%0d idx=%0d want 3 7", cyc, rsp_err_index);
        end
        enable     = 1'b1;
        req_access = ACCESS_WRITE;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_err, rsp_err_type, rsp_err_index} !== {1'b1, 1'b0, 1'b1, 3'd1, 16'd7}) begin
                errors++;
                $display("FAIL b2b hold %0d: vld=%0b ready=%0b err=%0b type=%0d idx=%0d want 1 0 1 1 7",
                         i, rsp_valid, req_ready, rsp_err, rsp_err_type, rsp_err_index);
            end
        end
        set_tables(16'h0001, 16'h0000);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b ready: got %0b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || win_offset !== 9'd0) begin
            errors++; $display("FAIL b2b scan: vld=%0b ready=%0b off=%0d want 0 0 0", rsp_valid, req_ready, win_offset);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_err_type, rsp_err_index} !== {1'b1, 1'b1, 3'd2, 16'd0}) begin
            errors++;
            $display("FAIL b2b second: vld=%0b err=%0b type=%0d idx=%0d want 1 1 2 0", rsp_valid, rsp_err, rsp_err_type, rsp_err_index);
        end
        release_rsp();
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        set_tables(16'h0000, 16'h0000);
        req_access = ACCESS_READ;
        enable     = 1'b1;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, win_offset, rsp_valid} !== {1'b1, 9'd0, 1'b0}) begin
            errors++; $display("FAIL reset_mid_scan: ready=%0b off=%0d vld=%0b want 1 0 0", req_ready, win_offset, rsp_valid);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_drop: rsp_valid seen=%0b want 0", seen); end
    endtask

    initial begin
        set_tables(16'h0000, 16'h0000);
        test_reset();
        test_hit_win2();
        test_priority();
        test_allow_and_unknown();
        test_no_hit();
        test_disabled();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
